// File: rtl/update_table_writer.sv
// Write-side table updater: applies one insert/delete request at a time to a
// chained hash table. Walks the bucket chain from the head slot, detects
// duplicates, reuses a freed slot or appends from an overflow bump allocator,
// then pulses a status response.
module update_table_writer #(
  parameter int TABLE_ENTRY_SIZE = 1738,
  parameter int OVF_BASE         = 1024,
  parameter int MAX_HOPS         = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_op,
  input  logic [10:0]  req_index,
  input  logic [10:0]  req_ruleID,
  input  logic [103:0] req_tuple,
  output logic [10:0]  tbl_addr,
  output logic         tbl_re,
  input  logic [126:0] tbl_rdata,
  output logic         tbl_we,
  output logic [126:0] tbl_wdata,
  output logic         busy,
  output logic         rsp_valid,
  output logic [1:0]   rsp_status,
  output logic [10:0]  rsp_addr
);

  localparam logic [10:0] NULL_PTR = 11'h7FF;
  localparam int          HW       = $clog2(MAX_HOPS + 1);
  localparam int          FPW      = 12;

  localparam logic [1:0] ST_OK   = 2'd0;
  localparam logic [1:0] ST_MISS = 2'd1;  // duplicate on insert, absent on delete
  localparam logic [1:0] ST_FULL = 2'd2;
  localparam logic [1:0] ST_HOP  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CHK, S_WR_NEW, S_WR_LINK, S_RESP
  } state_t;

  // What the CHK cycle decided to do with the entry just read
  typedef enum logic [1:0] {
    A_NEXT,    // follow next pointer
    A_RESP,    // finish without writing
    A_WRITE,   // single write (delete-clear or slot reuse)
    A_APPEND   // new entry at free_ptr, then relink the tail
  } act_t;

  state_t            state;
  logic              op_q;
  logic [10:0]       id_q;
  logic [103:0]      tuple_q;
  logic [10:0]       cur;
  logic [HW-1:0]     hops;
  logic [10:0]       hole;
  logic [10:0]       hole_next;
  logic [FPW-1:0]    free_ptr;
  logic              link_pend;
  logic [126:0]      link_data;
  logic [10:0]       res_addr;

  // Entry fields of the read data
  logic              e_valid;
  logic [10:0]       e_id;
  logic [10:0]       e_next;
  logic [103:0]      e_tuple;

  logic              hit;
  logic              take_hole;
  logic [10:0]       hole_n;
  logic [10:0]       hole_next_n;
  logic              at_end;
  logic              has_room;
  act_t              act;
  logic [1:0]        chk_status;
  logic [10:0]       wr_addr_c;
  logic [126:0]      wr_data_c;

  // Decode the entry returned for the current hop and pick the next action
  always_comb begin
    e_valid     = tbl_rdata[126];
    e_id        = tbl_rdata[125:115];
    e_next      = tbl_rdata[114:104];
    e_tuple     = tbl_rdata[103:0];
    hit         = e_valid && (e_id == id_q);
    // The first freed slot seen on an insert walk is remembered for reuse;
    // its next pointer is kept so the chain behind it stays reachable.
    take_hole   = !op_q && !e_valid && (hole == NULL_PTR);
    hole_n      = take_hole ? cur    : hole;
    hole_next_n = take_hole ? e_next : hole_next;
    // An invalid head terminates the walk: its stale next is not trusted.
    at_end      = (e_next == NULL_PTR) || (!e_valid && (hops == HW'(1)));
    has_room    = free_ptr < FPW'(TABLE_ENTRY_SIZE);
    act         = A_NEXT;
    chk_status  = ST_OK;
    wr_addr_c   = '0;
    wr_data_c   = '0;
    if (hit) begin
      if (!op_q) begin
        act        = A_RESP;
        chk_status = ST_MISS;
      end else begin
        act       = A_WRITE;
        wr_addr_c = cur;
        wr_data_c = {1'b0, tbl_rdata[125:0]};
      end
    end else if (at_end) begin
      if (op_q) begin
        act        = A_RESP;
        chk_status = ST_MISS;
      end else if (hole_n != NULL_PTR) begin
        act       = A_WRITE;
        wr_addr_c = hole_n;
        wr_data_c = {1'b1, id_q, hole_next_n, tuple_q};
      end else if (has_room) begin
        act       = A_APPEND;
        wr_addr_c = free_ptr[10:0];
        wr_data_c = {1'b1, id_q, NULL_PTR, tuple_q};
      end else begin
        act        = A_RESP;
        chk_status = ST_FULL;
      end
    end else if (hops == HW'(MAX_HOPS)) begin
      act        = A_RESP;
      chk_status = ST_HOP;
    end
  end

  // Request FSM with registered table strobes and response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      tbl_re     <= 1'b0;
      tbl_we     <= 1'b0;
      rsp_valid  <= 1'b0;
      tbl_addr   <= '0;
      tbl_wdata  <= '0;
      rsp_status <= '0;
      rsp_addr   <= '0;
      free_ptr   <= FPW'(OVF_BASE);
      op_q       <= 1'b0;
      id_q       <= '0;
      tuple_q    <= '0;
      cur        <= '0;
      hops       <= '0;
      hole       <= NULL_PTR;
      hole_next  <= NULL_PTR;
      link_pend  <= 1'b0;
      link_data  <= '0;
      res_addr   <= '0;
    end else begin
      tbl_re    <= 1'b0;
      tbl_we    <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            id_q      <= req_ruleID;
            tuple_q   <= req_tuple;
            cur       <= req_index;
            hops      <= '0;
            hole      <= NULL_PTR;
            hole_next <= NULL_PTR;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            tbl_re    <= 1'b1;
            tbl_addr  <= req_index;
            state     <= S_RD;
          end
        end
        S_RD: begin
          hops  <= hops + HW'(1);
          state <= S_CHK;
        end
        S_CHK: begin
          hole      <= hole_n;
          hole_next <= hole_next_n;
          case (act)
            A_NEXT: begin
              cur      <= e_next;
              tbl_re   <= 1'b1;
              tbl_addr <= e_next;
              state    <= S_RD;
            end
            A_RESP: begin
              rsp_valid  <= 1'b1;
              busy       <= 1'b0;
              rsp_status <= chk_status;
              rsp_addr   <= '0;
              state      <= S_RESP;
            end
            default: begin
              // The new entry always lands first; the tail relink (append
              // only) follows, so a reader never sees a dangling pointer.
              tbl_we    <= 1'b1;
              tbl_addr  <= wr_addr_c;
              tbl_wdata <= wr_data_c;
              res_addr  <= wr_addr_c;
              link_pend <= (act == A_APPEND);
              link_data <= {e_valid, e_id, free_ptr[10:0], e_tuple};
              state     <= S_WR_NEW;
            end
          endcase
        end
        S_WR_NEW: begin
          if (link_pend) begin
            tbl_we    <= 1'b1;
            tbl_addr  <= cur;
            tbl_wdata <= link_data;
            free_ptr  <= free_ptr + FPW'(1);
            state     <= S_WR_LINK;
          end else begin
            rsp_valid  <= 1'b1;
            busy       <= 1'b0;
            rsp_status <= ST_OK;
            rsp_addr   <= res_addr;
            state      <= S_RESP;
          end
        end
        S_WR_LINK: begin
          rsp_valid  <= 1'b1;
          busy       <= 1'b0;
          rsp_status <= ST_OK;
          rsp_addr   <= res_addr;
          state      <= S_RESP;
        end
        S_RESP: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_update_table_writer.sv
// Bench for update_table_writer: a behavioural table RAM answers the DUT, and
// an op-level reference model predicts status, response address, write list
// and latency for each request.
module tb_update_table_writer;

  localparam int TES = 1072;
  localparam int OVF = 1024;
  localparam int MH  = 16;
  localparam logic [10:0] NUL = 11'h7FF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_op = 1'b0;
  logic [10:0]  req_index = '0;
  logic [10:0]  req_ruleID = '0;
  logic [103:0] req_tuple = '0;
  logic [10:0]  tbl_addr;
  logic         tbl_re;
  logic [126:0] tbl_rdata;
  logic         tbl_we;
  logic [126:0] tbl_wdata;
  logic         busy;
  logic         rsp_valid;
  logic [1:0]   rsp_status;
  logic [10:0]  rsp_addr;

  logic [126:0] ram  [0:2047];
  logic [126:0] mtab [0:2047];
  int           mfree;
  int           n_chk = 0;
  int           n_pass = 0;
  int           coll = 0;
  logic [10:0]  obs_a [$];
  logic [126:0] obs_d [$];
  logic [10:0]  exp_a [$];
  logic [126:0] exp_d [$];

  update_table_writer #(.TABLE_ENTRY_SIZE(TES), .OVF_BASE(OVF), .MAX_HOPS(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_index(req_index), .req_ruleID(req_ruleID),
    .req_tuple(req_tuple), .tbl_addr(tbl_addr), .tbl_re(tbl_re),
    .tbl_rdata(tbl_rdata), .tbl_we(tbl_we), .tbl_wdata(tbl_wdata),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .rsp_addr(rsp_addr)
  );

  always #5 clk = ~clk;

  // Table RAM with one-cycle read latency
  always @(posedge clk) begin
    if (tbl_we) ram[tbl_addr] <= tbl_wdata;
    if (tbl_re) tbl_rdata <= ram[tbl_addr];
  end

  // Write and strobe-overlap monitor
  always @(negedge clk) begin
    if (tbl_we) begin
      obs_a.push_back(tbl_addr);
      obs_d.push_back(tbl_wdata);
    end
    if (tbl_re && tbl_we) coll <= coll + 1;
  end

  task automatic chk(input string tag, input logic [126:0] got, input logic [126:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [103:0] rtup();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[103:0];
  endfunction

  task automatic mwr(input logic [10:0] a, input logic [126:0] d);
    mtab[a] = d;
    exp_a.push_back(a);
    exp_d.push_back(d);
  endtask

  // Reference: walk the chain as a loop over the model table
  task automatic model_op(input logic op, input logic [10:0] idx, input logic [10:0] id,
                          input logic [103:0] tup, output logic [1:0] st,
                          output logic [10:0] addr, output int h);
    logic [10:0]  cur, hole, hole_next;
    logic [126:0] e;
    bit           done;
    exp_a.delete();
    exp_d.delete();
    cur = idx; hole = NUL; hole_next = NUL; h = 0; done = 0; st = 0; addr = 0;
    while (!done) begin
      e = mtab[cur];
      h++;
      if (e[126] && e[125:115] == id) begin
        if (!op) st = 1;
        else begin
          mwr(cur, {1'b0, e[125:0]});
          addr = cur;
        end
        done = 1;
      end else begin
        if (!op && !e[126] && hole == NUL) begin
          hole = cur;
          hole_next = e[114:104];
        end
        if (e[114:104] == NUL || (!e[126] && h == 1)) begin
          if (op) st = 1;
          else if (hole != NUL) begin
            mwr(hole, {1'b1, id, hole_next, tup});
            addr = hole;
          end else if (mfree < TES) begin
            mwr(11'(mfree), {1'b1, id, NUL, tup});
            mwr(cur, {e[126:115], 11'(mfree), e[103:0]});
            addr = 11'(mfree);
            mfree++;
          end else st = 2;
          done = 1;
        end else if (h == MH) begin
          st = 3;
          done = 1;
        end else cur = e[114:104];
      end
    end
  endtask

  task automatic do_op(input logic op, input logic [10:0] idx, input logic [10:0] id,
                       input logic [103:0] tup);
    logic [1:0]  est;
    logic [10:0] eaddr;
    int h, cyc, ob, cb, nw;
    bit got;
    model_op(op, idx, id, tup, est, eaddr, h);
    nw = exp_a.size();
    ob = obs_a.size();
    cb = coll;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_index = idx; req_ruleID = id; req_tuple = tup;
    cyc = 0;
    while (!req_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("busy_ready", {125'd0, busy, req_ready}, 127'b10);
    cyc = 1;
    got = 0;
    while (cyc < 200) begin
      if (rsp_valid) begin
        got = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (!got) chk("rsp_timeout", 0, 1);
    else begin
      chk("status", rsp_status, est);
      chk("rsp_addr", rsp_addr, eaddr);
      chk("latency", cyc, 2 * h + nw + 1);
      chk("busy_low", busy, 0);
      chk("nwrites", obs_a.size() - ob, nw);
      for (int i = 0; i < nw && ob + i < obs_a.size(); i++) begin
        chk("wr_addr", obs_a[ob + i], exp_a[i]);
        chk("wr_data", obs_d[ob + i], exp_d[i]);
      end
      chk("re_we_excl", coll - cb, 0);
    end
  endtask

  task automatic rand_ops(input int n);
    logic [10:0] idxs [4];
    idxs = '{11'd3, 11'd5, 11'd8, 11'd9};
    for (int i = 0; i < n; i++)
      do_op($urandom_range(0, 2) == 0, idxs[$urandom_range(0, 3)],
            11'($urandom_range(1, 20)), rtup());
  endtask

  initial begin
    logic [103:0] t4;
    int k, ob;
    for (int i = 0; i < 2048; i++) begin
      ram[i]  = {1'b0, 11'd0, NUL, 104'd0};
      mtab[i] = {1'b0, 11'd0, NUL, 104'd0};
    end
    mfree = OVF;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_strobes", {124'd0, busy, tbl_re, tbl_we}, 0);
    chk("rst_rsp", {113'd0, rsp_valid, rsp_status, rsp_addr}, 0);
    chk("rst_tbl", {tbl_addr, tbl_wdata}, 0);
    rst_n = 1'b1;

    // Directed scenarios at bucket 3
    do_op(1'b0, 11'd3, 11'd5, rtup());
    do_op(1'b0, 11'd3, 11'd9, rtup());
    do_op(1'b0, 11'd3, 11'd5, rtup());
    do_op(1'b1, 11'd3, 11'd5, rtup());
    t4 = rtup();
    do_op(1'b0, 11'd3, 11'd12, t4);
    chk("t4_reuse", ram[3], {1'b1, 11'd12, 11'd1024, t4});
    do_op(1'b1, 11'd3, 11'd77, rtup());

    // Long chain at bucket 0, then one more insert runs out of hops
    for (int i = 0; i < 17; i++) do_op(1'b0, 11'd0, 11'(100 + i), rtup());
    do_op(1'b0, 11'd0, 11'd117, rtup());

    rand_ops(120);

    // Exhaust the overflow area, then an append must report FULL
    k = 0;
    while (mfree < TES && k < 60) begin
      do_op(1'b0, 11'(40 + k), 11'd1, rtup());
      do_op(1'b0, 11'(40 + k), 11'd2, rtup());
      k++;
    end
    do_op(1'b0, 11'd200, 11'd1, rtup());
    do_op(1'b0, 11'd200, 11'd2, rtup());

    // Reset during the read of a walk: op is abandoned without writes
    ob = obs_a.size();
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b0; req_index = 11'd0; req_ruleID = 11'd300; req_tuple = rtup();
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rd_strobe", tbl_re, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_strobes", {124'd0, busy, tbl_re, tbl_we}, 0);
    chk("mid_rst_rsp", {113'd0, rsp_valid, rsp_status, rsp_addr}, 0);
    chk("mid_rst_tbl", {tbl_addr, tbl_wdata}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_nowr", obs_a.size() - ob, 0);
    mfree = OVF;

    rand_ops(30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
